// File: rtl/booth_divider_seq_if.sv
// Handshake and operand/result bundle for booth_divider_seq.
//   master: drives start, dividend, divisor; observes status and results
//   slave : the divider itself
// start/dividend/divisor : request and signed operands, sampled while the divider is idle
// busy/done              : in-progress level and one-cycle completion pulse
// quotient/remainder     : signed results, held until the next done
// div_by_zero/overflow   : result flags, held with the results
interface booth_divider_seq_if #(
  parameter int unsigned DIVIDEND_W = 16,
  parameter int unsigned DIVISOR_W  = 8
);
  logic                  start;
  logic [DIVIDEND_W-1:0] dividend;
  logic [DIVISOR_W-1:0]  divisor;
  logic                  busy;
  logic                  done;
  logic [DIVIDEND_W-1:0] quotient;
  logic [DIVISOR_W-1:0]  remainder;
  logic                  div_by_zero;
  logic                  overflow;

  modport master (
    output start, dividend, divisor,
    input  busy, done, quotient, remainder, div_by_zero, overflow
  );

  modport slave (
    input  start, dividend, divisor,
    output busy, done, quotient, remainder, div_by_zero, overflow
  );
endinterface

// File: rtl/booth_divider_seq.sv
// Sequential signed divider, restoring shift-subtract, one quotient bit per clock.
// Truncating (round-toward-zero) quotient; remainder carries the dividend's sign.
// Ports:
//   clk : clock, rising edge
//   rst : asynchronous active-high reset; aborts any operation in flight
//   bus : booth_divider_seq_if slave (start/busy/done handshake, operands, results, flags)
// Requires DIVISOR_W <= DIVIDEND_W and DIVIDEND_W >= 2.
module booth_divider_seq #(
  parameter int unsigned DIVIDEND_W = 16,
  parameter int unsigned DIVISOR_W  = 8
) (
  input logic               clk,
  input logic               rst,
  booth_divider_seq_if.slave bus
);

  localparam int unsigned CW = $clog2(DIVIDEND_W);

  typedef enum logic [1:0] {StIdle, StPrep, StIter, StFix} state_e;

  state_e                state_q, state_d;
  logic [CW-1:0]         cnt_q;
  logic [DIVIDEND_W-1:0] dvd_q, acc_q;
  logic [DIVISOR_W-1:0]  dsr_q;
  logic [DIVISOR_W:0]    rem_q;
  logic [DIVIDEND_W-1:0] quotient_q;
  logic [DIVISOR_W-1:0]  remainder_q;
  logic                  done_q, dbz_q, ovf_q;

  logic [DIVIDEND_W-1:0] dvd_mag, src_acc, step_acc, q_fix;
  logic [DIVISOR_W-1:0]  dsr_mag, rem_lo, r_fix;
  logic [DIVISOR_W:0]    src_rem, shifted, step_rem;
  logic [DIVISOR_W+1:0]  trial;
  logic                  qbit, dsr_zero, ovf_fix, q_neg, last_iter;

  // Datapath: one restoring step, plus sign fix-up for the FIX cycle
  always_comb begin
    // Unsigned negation keeps |-2^(W-1)| = 2^(W-1) exact in W bits
    dvd_mag   = dvd_q[DIVIDEND_W-1] ? -dvd_q : dvd_q;
    dsr_mag   = dsr_q[DIVISOR_W-1]  ? -dsr_q : dsr_q;
    dsr_zero  = (dsr_q == '0);
    last_iter = (cnt_q == CW'(DIVIDEND_W - 1));

    // PREP runs the first step straight from the cleared remainder and fresh magnitude
    src_acc = (state_q == StPrep) ? dvd_mag : acc_q;
    src_rem = (state_q == StPrep) ? '0 : rem_q;

    // acc shifts dividend bits out of its MSB and quotient bits into its LSB
    shifted = {src_rem[DIVISOR_W-1:0], src_acc[DIVIDEND_W-1]};
    trial   = {1'b0, shifted} - {2'b00, dsr_mag};
    qbit    = ~trial[DIVISOR_W+1];
    step_rem = qbit ? trial[DIVISOR_W:0] : shifted;
    step_acc = {src_acc[DIVIDEND_W-2:0], qbit};

    q_neg   = dvd_q[DIVIDEND_W-1] ^ dsr_q[DIVISOR_W-1];
    q_fix   = q_neg ? -acc_q : acc_q;
    rem_lo  = rem_q[DIVISOR_W-1:0];
    r_fix   = dvd_q[DIVIDEND_W-1] ? -rem_lo : rem_lo;
    ovf_fix = (dvd_q == {1'b1, {(DIVIDEND_W-1){1'b0}}}) && (dsr_q == '1);
  end

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= StIdle;
    else     state_q <= state_d;
  end

  // FSM next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (bus.start) state_d = StPrep;
      StPrep: state_d = dsr_zero ? StFix : StIter;
      StIter: if (last_iter) state_d = StFix;
      StFix:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Operand capture, iteration state and result registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q       <= '0;
      dvd_q       <= '0;
      dsr_q       <= '0;
      acc_q       <= '0;
      rem_q       <= '0;
      quotient_q  <= '0;
      remainder_q <= '0;
      done_q      <= 1'b0;
      dbz_q       <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (bus.start) begin
            dvd_q <= bus.dividend;
            dsr_q <= bus.divisor;
          end
        end
        StPrep: begin
          acc_q <= step_acc;
          rem_q <= step_rem;
          cnt_q <= CW'(1);
        end
        StIter: begin
          acc_q <= step_acc;
          rem_q <= step_rem;
          cnt_q <= cnt_q + CW'(1);
        end
        StFix: begin
          done_q      <= 1'b1;
          dbz_q       <= dsr_zero;
          ovf_q       <= ovf_fix;
          quotient_q  <= dsr_zero ? '1 : q_fix;
          remainder_q <= dsr_zero ? '0 : r_fix;
          cnt_q       <= '0;
        end
        default: ;
      endcase
    end
  end

  // Outputs
  always_comb begin
    bus.busy        = (state_q != StIdle);
    bus.done        = done_q;
    bus.quotient    = quotient_q;
    bus.remainder   = remainder_q;
    bus.div_by_zero = dbz_q;
    bus.overflow    = ovf_q;
  end

endmodule

// File: tb/tb_booth_divider_seq.sv
module tb_booth_divider_seq;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;

  booth_divider_seq_if #(.DIVIDEND_W(16), .DIVISOR_W(8)) bus ();

  booth_divider_seq #(.DIVIDEND_W(16), .DIVISOR_W(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [15:0] q;
    logic [7:0]  r;
    logic        dbz;
    logic        ovf;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every done pulse is matched against the oldest expectation
  always @(negedge clk) begin
    if (!rst && bus.done) begin
      if (sb.size() == 0) begin
        chk("unexpected_done", {31'b0, bus.done}, 32'd0);
      end else begin
        mon_e = sb.pop_front();
        chk("quotient",    {16'b0, bus.quotient},  {16'b0, mon_e.q});
        chk("remainder",   {24'b0, bus.remainder}, {24'b0, mon_e.r});
        chk("div_by_zero", {31'b0, bus.div_by_zero}, {31'b0, mon_e.dbz});
        chk("overflow",    {31'b0, bus.overflow},  {31'b0, mon_e.ovf});
        chk("done_cycle",  cyc, mon_e.cyc);
        chk("busy_in_done", {31'b0, bus.busy}, 32'd0);
      end
    end
  end

  // Called at a negedge; start is sampled at the next rising edge (T0)
  task automatic issue(input logic [15:0] a, input logic [7:0] b, input logic [15:0] q,
                       input logic [7:0] r, input logic dbz, input logic ovf, input int lat,
                       output int t0);
    exp_t e;
    bus.start    = 1'b1;
    bus.dividend = a;
    bus.divisor  = b;
    t0 = cyc + 1;
    e.q = q; e.r = r; e.dbz = dbz; e.ovf = ovf; e.cyc = t0 + lat;
    sb.push_back(e);
    @(negedge clk);
    bus.start = 1'b0;
    chk("busy_after_start", {31'b0, bus.busy}, 32'd1);
  endtask

  task automatic wait_done();
    int n = 0;
    while (!bus.done && n < 40) begin
      chk("busy_during_op", {31'b0, bus.busy}, 32'd1);
      @(negedge clk);
      n++;
    end
    if (!bus.done) chk("done_timeout", {31'b0, bus.done}, 32'd1);
  endtask

  initial begin
    int t0;
    rst          = 1'b1;
    bus.start    = 1'b0;
    bus.dividend = '0;
    bus.divisor  = '0;
    #3;
    chk("rst_busy",      {31'b0, bus.busy}, 32'd0);
    chk("rst_done",      {31'b0, bus.done}, 32'd0);
    chk("rst_quotient",  {16'b0, bus.quotient}, 32'd0);
    chk("rst_remainder", {24'b0, bus.remainder}, 32'd0);
    chk("rst_dbz",       {31'b0, bus.div_by_zero}, 32'd0);
    chk("rst_ovf",       {31'b0, bus.overflow}, 32'd0);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Basic and sign combinations
    issue(16'd1000, 8'd7,    16'd142,   8'd6,   1'b0, 1'b0, 17, t0); wait_done(); @(negedge clk);
    issue(16'hFC18, 8'd7,    16'hFF72,  8'hFA,  1'b0, 1'b0, 17, t0); wait_done(); @(negedge clk);
    issue(16'd1000, 8'hF9,   16'hFF72,  8'd6,   1'b0, 1'b0, 17, t0); wait_done(); @(negedge clk);
    issue(16'hFC18, 8'hF9,   16'd142,   8'hFA,  1'b0, 1'b0, 17, t0); wait_done(); @(negedge clk);
    issue(16'd127,  8'h80,   16'd0,     8'd127, 1'b0, 1'b0, 17, t0); wait_done(); @(negedge clk);

    // Overflow and most-negative dividend
    issue(16'h8000, 8'hFF,   16'h8000,  8'd0,   1'b0, 1'b1, 17, t0); wait_done(); @(negedge clk);
    issue(16'h8000, 8'd1,    16'h8000,  8'd0,   1'b0, 1'b0, 17, t0); wait_done(); @(negedge clk);

    // Divide by zero, then a normal op clears the flag
    issue(16'd1234, 8'd0,    16'hFFFF,  8'd0,   1'b1, 1'b0, 2,  t0); wait_done(); @(negedge clk);
    issue(16'd10,   8'd3,    16'd3,     8'd1,   1'b0, 1'b0, 17, t0); wait_done(); @(negedge clk);

    // start while busy is ignored
    issue(16'd1000, 8'd7,    16'd142,   8'd6,   1'b0, 1'b0, 17, t0);
    while (cyc < t0 + 4) @(negedge clk);
    bus.start = 1'b1; bus.dividend = 16'd5; bus.divisor = 8'd1;
    @(negedge clk);
    bus.start = 1'b0;
    wait_done();
    repeat (20) @(negedge clk);

    // Back-to-back: start during the done cycle; old results hold until the new FIX
    issue(16'd1000, 8'hF9,   16'hFF72,  8'd6,   1'b0, 1'b0, 17, t0); wait_done();
    issue(16'hFC18, 8'hF9,   16'd142,   8'hFA,  1'b0, 1'b0, 17, t0);
    while (cyc < t0 + 5) @(negedge clk);
    chk("held_quotient",  {16'b0, bus.quotient},  32'h0000FF72);
    chk("held_remainder", {24'b0, bus.remainder}, 32'h00000006);
    wait_done(); @(negedge clk);

    // Asynchronous reset mid-ITER aborts with no done
    issue(16'd1000, 8'd7,    16'd142,   8'd6,   1'b0, 1'b0, 17, t0);
    while (cyc < t0 + 8) @(negedge clk);
    #1 rst = 1'b1;
    sb.delete();
    #1;
    chk("abort_busy",      {31'b0, bus.busy}, 32'd0);
    chk("abort_done",      {31'b0, bus.done}, 32'd0);
    chk("abort_quotient",  {16'b0, bus.quotient}, 32'd0);
    chk("abort_remainder", {24'b0, bus.remainder}, 32'd0);
    chk("abort_dbz",       {31'b0, bus.div_by_zero}, 32'd0);
    chk("abort_ovf",       {31'b0, bus.overflow}, 32'd0);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    issue(16'd100,  8'hF7,   16'hFFF5,  8'd1,   1'b0, 1'b0, 17, t0); wait_done();

    repeat (20) @(negedge clk);
    chk("scoreboard_empty", sb.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
